vram_arbiter: RTL

//  Shares one synchronous single-port video RAM between the scanout pixel fetch
//  and a CPU bus. The pixel fetch always wins; CPU writes queue in a small FIFO.
//  The FIFO and CPU reads use cycles with no pixel fetch, or blanking only.

---
 rtl/vram_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port VRAM between scanout fetch (always wins) and a CPU write FIFO / read port.
// Optional macro BLANK_ONLY_EN confines CPU write/read grants to horizontal or vertical blanking.
module vram_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hblank_n,
  input  logic              vblank_n,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_wait,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata,
  output logic [1:0]        grant
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              rd_pend, rd_pend_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic              wait_q;
  logic              pix_vld_p1, rd_vld_p1;
  logic              cpu_ok, push, rd_acc;
  logic              gnt_pix, gnt_wr, gnt_rd;

`ifdef BLANK_ONLY_EN
  assign cpu_ok = !hblank_n || !vblank_n;
`else
  logic blank_unused;
  assign blank_unused = hblank_n ^ vblank_n;
  assign cpu_ok = 1'b1;
`endif

  assign push   = cpu_wr && !wait_q;
  assign rd_acc = cpu_rd && !wait_q;

  // p0: grant decode, RAM address/command phase
  always_comb begin
    gnt_pix = 1'b0;
    gnt_wr  = 1'b0;
    gnt_rd  = 1'b0;
    if (!reset) begin
      if (pix_req)
        gnt_pix = 1'b1;
      else if (cpu_ok && count != '0)
        gnt_wr = 1'b1;
      else if (cpu_ok && rd_pend)
        gnt_rd = 1'b1;
    end
  end

  assign grant      = {gnt_wr | gnt_rd, gnt_pix | gnt_rd};
  assign vram_we    = gnt_wr;
  assign vram_wdata = gnt_wr ? fifo_data[rd_ptr] : '0;

  always_comb begin
    vram_addr = '0;
    if (gnt_pix)
      vram_addr = pix_addr;
    else if (gnt_wr)
      vram_addr = fifo_addr[rd_ptr];
    else if (gnt_rd)
      vram_addr = rd_addr;
  end

  always_comb begin
    count_nxt = count;
    if (push && !gnt_wr)
      count_nxt = count + CNT_W'(1);
    else if (!push && gnt_wr)
      count_nxt = count - CNT_W'(1);
    rd_pend_nxt = rd_pend;
    if (gnt_rd)
      rd_pend_nxt = 1'b0;
    // A read accepted with a write in the same cycle still waits for the FIFO to drain.
    if (rd_acc)
      rd_pend_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_pend    <= 1'b0;
      wait_q     <= 1'b0;
      pix_vld_p1 <= 1'b0;
      rd_vld_p1  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (gnt_wr)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_nxt;
      rd_pend    <= rd_pend_nxt;
      wait_q     <= (count_nxt == FULL) || rd_pend_nxt;
      pix_vld_p1 <= gnt_pix;
      rd_vld_p1  <= gnt_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_wdata;
    end
    if (rd_acc)
      rd_addr <= cpu_addr;
  end

  // p1: RAM data return
  assign pix_valid  = pix_vld_p1;
  assign pix_data   = pix_vld_p1 ? vram_rdata : '0;
  assign cpu_rvalid = rd_vld_p1;
  assign cpu_rdata  = rd_vld_p1 ? vram_rdata : '0;
  assign cpu_wait   = wait_q;

endmodule
